ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Instruction sequencer and decoder that sits directly upstream of the accumulator/ALU/flags datapath. It fetches 16-bit instruction words from program memory over a request/valid handshake, decodes them, and drives the datapath controls: source select, immediate, ALU op, accumulator and carry clock-enables. It also consumes the datapath's registered flags to resolve conditional jumps.

## Interface
- WIDTH, 8, datapath width; immediate and jump target width.
- PC_WIDTH, 8, program counter and instruction-address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; high only in FETCH.
- imem_addr  output  PC_WIDTH  fetch address; equals pc.
- imem_valid  input  1  instruction word present on imem_data this cycle.
- imem_data  input  16  instruction word.
- data_src  output  data_src_t  ALU operand source, ir[10:9]: ?0 mem, 01 imm, 11 reg.
- immediate  output  WIDTH  ir[7:0], zero-extended when WIDTH > 8; also used as the memory address.
- op  output  3  ALU operation, ir[13:11].
- ce_a  output  1  accumulator/flag write enable; one-cycle pulse.
- ce_cy  output  1  carry write enable; one-cycle pulse.
- flag_cy, flag_z, flag_s, flag_o  input  1 each  registered flags from the datapath.
- halted  output  1  high while in HALT.

## Operation
- Instruction class is ir[15:14]:
  - 00 ALU: op = ir[13:11], src = ir[10:9], ir[8] = cy_we, imm = ir[7:0].
  - 01 JMP: cond = ir[13:11], target = ir[7:0] (zero-extended or truncated to PC_WIDTH).
  - 10 NOP.
  - 11 HALT.
- Jump condition codes: 000 always, 001 Z, 010 NZ, 011 CY, 100 NC, 101 S, 110 O, 111 never.
- FSM states: FETCH, EXEC, HALT.
  - FETCH: imem_req = 1, imem_addr = pc. When imem_valid is high: latch imem_data into ir, pc <= pc + 1 (wraps modulo 2^PC_WIDTH), go to EXEC. Otherwise stay in FETCH with address held stable.
  - EXEC, ALU class: ce_a = 1; ce_cy = cy_we. op, data_src and immediate are driven from ir. Then FETCH.
  - EXEC, JMP class: evaluate cond against the flag inputs in this cycle. If taken, pc <= target. Then FETCH.
  - EXEC, NOP class: no enables. Then FETCH.
  - EXEC, HALT class: go to HALT.
  - HALT: absorbing; no requests and no enables. Left only via rst.
- op, data_src and immediate are decoded combinationally from ir in every state. They are qualified only by ce_a/ce_cy, which are zero outside EXEC.
- imem_data is ignored when imem_valid is high outside FETCH.

## Timing
- Reset values: state = FETCH, pc = 0, ir = 16'h8000 (NOP).
  - While rst is high: imem_req = 0, ce_a = 0, ce_cy = 0, halted = 0.
  - imem_addr = 0, op = 0, data_src = 2'b00, immediate = 0.
- Reset mid-handshake or mid-EXEC: the pending fetch is abandoned and no enable is issued. The first request after reset is to address 0.
- Minimum 2 cycles per instruction (FETCH with imem_valid already high, then EXEC). Each wait cycle adds 1.
- ALU result and flags are visible on the datapath's registered outputs in the cycle after EXEC, i.e. during the next FETCH. A JMP immediately following an ALU instruction therefore sees the updated flags.
- Taken jump: the next imem_addr equals target. Not taken: pc + 1.
- Jump to its own address (target == pc - 1) loops indefinitely without error.
- pc wrap from 2^PC_WIDTH-1 to 0 is silent.

## Configuration
- Macro: CTRL_SEQ_RETIRE_CNT_EN.
- Defined:
  - Adds output port retired_cnt, 16 bits, reset to 0.
  - Increments by 1 on every EXEC cycle, including HALT-class; wraps at 16'hFFFF.
  - Does not increment in HALT state.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Reset hold: rst high for 3 cycles with imem_valid = 1 -> imem_req = 0, ce_a = 0, ce_cy = 0. After release, imem_req = 1 and imem_addr = 0.
- ALU op: word 16'h0B2A (ALU, op 001, src imm, cy_we 1, imm 0x2A), imem_valid delayed 3 cycles -> addr held at 0 through the wait, then one EXEC cycle with op = 1, data_src = 01, immediate = 0x2A, ce_a = 1, ce_cy = 1. Next fetch at addr 1.
- Conditional jump: flag_z = 1, word 16'h4810 (JZ 0x10) -> next imem_addr = 0x10. Repeat with flag_z = 0 -> next imem_addr = pc + 1.
- Never/always jump: cond 111 with all flags set -> not taken. cond 000 with target 0xFF -> addr 0xFF. Then a NOP at 0xFF -> next addr 0x00 (wrap).
- HALT: word 16'hC000 -> halted = 1 and imem_req = 0 permanently. rst then restarts fetch at addr 0 with halted = 0.
- CTRL_SEQ_RETIRE_CNT_EN: run NOP, ALU, JMP, HALT -> retired_cnt = 4 and remains 4 while halted.

Source files
------------

// File: rtl/ctrl_seq.sv
// ctrl_seq: fetches 16-bit instruction words, decodes them and drives the accumulator/ALU/flags datapath controls.
// Optional feature: define CTRL_SEQ_RETIRE_CNT_EN to add the 16-bit retired_cnt output.

package ctrl_seq_pkg;
    // ?0 = memory operand, 01 = immediate, 11 = register.
    typedef logic [1:0] data_src_t;
endpackage

module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_valid,
    input  logic [15:0]         imem_data,
    output data_src_t           data_src,
    output logic [WIDTH-1:0]    immediate,
    output logic [2:0]          op,
    output logic                ce_a,
    output logic                ce_cy,
    input  logic                flag_cy,
    input  logic                flag_z,
    input  logic                flag_s,
    input  logic                flag_o,
    output logic                halted,
`ifdef CTRL_SEQ_RETIRE_CNT_EN
    output logic [15:0]         retired_cnt,
`endif
    output logic [1:0]          dbg_state
);

    // Fetch handshake: imem_req is high in every FETCH cycle; a word is accepted
    // on the rising edge where imem_req and imem_valid are both high, and
    // imem_valid is ignored in any other cycle.

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_JMP  = 2'b01;
    localparam logic [1:0] CLS_NOP  = 2'b10;
    localparam logic [1:0] CLS_HALT = 2'b11;

    localparam logic [15:0] IR_NOP = 16'h8000;

    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;

    logic [15:0]         ir_eff;
    logic [1:0]          ir_class;
    logic [2:0]          ir_cond;
    logic                ir_cy_we;
    logic [7:0]          ir_imm;
    logic [PC_WIDTH-1:0] jmp_target;
    logic                jmp_taken;
    logic                in_fetch;
    logic                in_exec;

    // During reset the decode sees a NOP so every decoded output reads zero.
    assign ir_eff   = rst ? IR_NOP : ir_q;
    assign ir_class = ir_eff[15:14];
    assign ir_cond  = ir_eff[13:11];
    assign ir_cy_we = ir_eff[8];
    assign ir_imm   = ir_eff[7:0];

    assign in_fetch = (state_q == ST_FETCH) && !rst;
    assign in_exec  = (state_q == ST_EXEC) && !rst;

    generate
        if (WIDTH > 8) begin : g_imm_ext
            assign immediate = {{(WIDTH-8){1'b0}}, ir_imm};
        end else begin : g_imm_trunc
            assign immediate = ir_imm[WIDTH-1:0];
        end
        if (PC_WIDTH > 8) begin : g_tgt_ext
            assign jmp_target = {{(PC_WIDTH-8){1'b0}}, ir_imm};
        end else begin : g_tgt_trunc
            assign jmp_target = ir_imm[PC_WIDTH-1:0];
        end
    endgenerate

    assign op       = ir_eff[13:11];
    assign data_src = data_src_t'(ir_eff[10:9]);

    always_comb begin
        jmp_taken = 1'b0;
        case (ir_cond)
            3'b000:  jmp_taken = 1'b1;
            3'b001:  jmp_taken = flag_z;
            3'b010:  jmp_taken = !flag_z;
            3'b011:  jmp_taken = flag_cy;
            3'b100:  jmp_taken = !flag_cy;
            3'b101:  jmp_taken = flag_s;
            3'b110:  jmp_taken = flag_o;
            default: jmp_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + PC_WIDTH'(1);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                if (ir_class == CLS_JMP && jmp_taken) begin
                    pc_d = jmp_target;
                end else if (ir_class == CLS_HALT) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= IR_NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign imem_req  = in_fetch;
    assign imem_addr = rst ? '0 : pc_q;
    assign ce_a      = in_exec && (ir_class == CLS_ALU);
    assign ce_cy     = in_exec && (ir_class == CLS_ALU) && ir_cy_we;
    assign halted    = (state_q == ST_HALT) && !rst;
    assign dbg_state = state_q;

`ifdef CTRL_SEQ_RETIRE_CNT_EN
    logic [15:0] retired_q, retired_d;

    // Every EXEC cycle retires one instruction, HALT-class included.
    always_comb begin
        retired_d = retired_q;
        if (state_q == ST_EXEC) begin
            retired_d = retired_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: a per-cycle vector table plus short hand-written
// sequences for reset-during-EXEC, self-loop jumps and the retire counter.
module tb_ctrl_seq;
    import ctrl_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    data_src_t   data_src;
    logic [7:0]  immediate;
    logic [2:0]  op;
    logic        ce_a;
    logic        ce_cy;
    logic        flag_cy, flag_z, flag_s, flag_o;
    logic        halted;
    logic [1:0]  dbg_state;
`ifdef CTRL_SEQ_RETIRE_CNT_EN
    logic [15:0] retired_cnt;
`endif

    int total;
    int bad;

    ctrl_seq #(.WIDTH(8), .PC_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .data_src   (data_src),
        .immediate  (immediate),
        .op         (op),
        .ce_a       (ce_a),
        .ce_cy      (ce_cy),
        .flag_cy    (flag_cy),
        .flag_z     (flag_z),
        .flag_s     (flag_s),
        .flag_o     (flag_o),
        .halted     (halted),
`ifdef CTRL_SEQ_RETIRE_CNT_EN
        .retired_cnt(retired_cnt),
`endif
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [15:0] data;
        logic [3:0]  flags;   // {cy, z, s, o}
        logic        e_req;
        logic [7:0]  e_addr;
        logic        e_ce_a;
        logic        e_ce_cy;
        logic [2:0]  e_op;
        logic [1:0]  e_src;
        logic [7:0]  e_imm;
        logic        e_halted;
        logic [15:0] e_ret;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [15:0] d, input logic [3:0] f,
                       input logic req, input logic [7:0] addr, input logic ca, input logic cc,
                       input logic [2:0] o, input logic [1:0] s, input logic [7:0] im,
                       input logic h, input logic [15:0] ret);
        vec_t x;
        x.rst = r; x.valid = v; x.data = d; x.flags = f;
        x.e_req = req; x.e_addr = addr; x.e_ce_a = ca; x.e_ce_cy = cc;
        x.e_op = o; x.e_src = s; x.e_imm = im; x.e_halted = h; x.e_ret = ret;
        vecs.push_back(x);
    endtask

    // driver: inputs change on the falling edge, outputs are sampled 1 ns later
    task automatic drive(input logic r, input logic v, input logic [15:0] d, input logic [3:0] f);
        @(negedge clk);
        rst = r; imem_valid = v; imem_data = d;
        {flag_cy, flag_z, flag_s, flag_o} = f;
        #1;
    endtask

    task automatic check_vec(input int i, input vec_t x);
        string t;
        t = $sformatf("v%0d", i);
        chk({t, ".req"},    {31'd0, imem_req},  {31'd0, x.e_req});
        chk({t, ".addr"},   {24'd0, imem_addr}, {24'd0, x.e_addr});
        chk({t, ".ce_a"},   {31'd0, ce_a},      {31'd0, x.e_ce_a});
        chk({t, ".ce_cy"},  {31'd0, ce_cy},     {31'd0, x.e_ce_cy});
        chk({t, ".op"},     {29'd0, op},        {29'd0, x.e_op});
        chk({t, ".src"},    {30'd0, data_src},  {30'd0, x.e_src});
        chk({t, ".imm"},    {24'd0, immediate}, {24'd0, x.e_imm});
        chk({t, ".halted"}, {31'd0, halted},    {31'd0, x.e_halted});
`ifdef CTRL_SEQ_RETIRE_CNT_EN
        chk({t, ".ret"},    {16'd0, retired_cnt}, {16'd0, x.e_ret});
`endif
    endtask

    // bounded wait for a fetch request with the given address
    task automatic wait_fetch(input string name, input logic [7:0] addr, input int budget);
        int n;
        n = 0;
        while (!imem_req && n < budget) begin
            drive(1'b0, 1'b0, 16'h0000, 4'h0);
            n++;
        end
        chk({name, ".req"}, {31'd0, imem_req}, 32'd1);
        chk({name, ".addr"}, {24'd0, imem_addr}, {24'd0, addr});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; imem_valid = 1'b0; imem_data = 16'h0000;
        {flag_cy, flag_z, flag_s, flag_o} = 4'h0;
        @(posedge clk);

        //   rst valid data     flags  req addr   ca cc op    src    imm    h   ret
        add(1, 1, 16'h0000, 4'h0,  0, 8'h00, 0, 0, 3'd0, 2'b00, 8'h00, 0, 16'd0);
        add(1, 1, 16'h0000, 4'h0,  0, 8'h00, 0, 0, 3'd0, 2'b00, 8'h00, 0, 16'd0);
        add(1, 1, 16'h0000, 4'h0,  0, 8'h00, 0, 0, 3'd0, 2'b00, 8'h00, 0, 16'd0);
        // ALU word with three wait cycles
        add(0, 0, 16'h0000, 4'h0,  1, 8'h00, 0, 0, 3'd0, 2'b00, 8'h00, 0, 16'd0);
        add(0, 0, 16'h0000, 4'h0,  1, 8'h00, 0, 0, 3'd0, 2'b00, 8'h00, 0, 16'd0);
        add(0, 0, 16'h0000, 4'h0,  1, 8'h00, 0, 0, 3'd0, 2'b00, 8'h00, 0, 16'd0);
        add(0, 1, 16'h0B2A, 4'h0,  1, 8'h00, 0, 0, 3'd0, 2'b00, 8'h00, 0, 16'd0);
        add(0, 0, 16'h0000, 4'h0,  0, 8'h01, 1, 1, 3'd1, 2'b01, 8'h2A, 0, 16'd0);
        // JZ 0x10 with Z set: taken
        add(0, 1, 16'h4810, 4'h4,  1, 8'h01, 0, 0, 3'd1, 2'b01, 8'h2A, 0, 16'd1);
        add(0, 0, 16'h0000, 4'h4,  0, 8'h02, 0, 0, 3'd1, 2'b00, 8'h10, 0, 16'd1);
        // JZ 0x10 with Z clear: not taken
        add(0, 1, 16'h4810, 4'h0,  1, 8'h10, 0, 0, 3'd1, 2'b00, 8'h10, 0, 16'd2);
        add(0, 0, 16'h0000, 4'h0,  0, 8'h11, 0, 0, 3'd1, 2'b00, 8'h10, 0, 16'd2);
        // cond never, all flags set
        add(0, 1, 16'h7810, 4'hF,  1, 8'h11, 0, 0, 3'd1, 2'b00, 8'h10, 0, 16'd3);
        add(0, 0, 16'h0000, 4'hF,  0, 8'h12, 0, 0, 3'd7, 2'b00, 8'h10, 0, 16'd3);
        // cond always to 0xFF
        add(0, 1, 16'h40FF, 4'h0,  1, 8'h12, 0, 0, 3'd7, 2'b00, 8'h10, 0, 16'd4);
        add(0, 0, 16'h0000, 4'h0,  0, 8'h13, 0, 0, 3'd0, 2'b00, 8'hFF, 0, 16'd4);
        // NOP at 0xFF, pc wraps to 0
        add(0, 1, 16'h8000, 4'h0,  1, 8'hFF, 0, 0, 3'd0, 2'b00, 8'hFF, 0, 16'd5);
        add(0, 0, 16'h0000, 4'h0,  0, 8'h00, 0, 0, 3'd0, 2'b00, 8'h00, 0, 16'd5);
        // HALT, then stray valid words are ignored
        add(0, 1, 16'hC000, 4'h0,  1, 8'h00, 0, 0, 3'd0, 2'b00, 8'h00, 0, 16'd6);
        add(0, 0, 16'h0000, 4'h0,  0, 8'h01, 0, 0, 3'd0, 2'b00, 8'h00, 0, 16'd6);
        add(0, 1, 16'h0B2A, 4'h0,  0, 8'h01, 0, 0, 3'd0, 2'b00, 8'h00, 1, 16'd7);
        add(0, 1, 16'h0B2A, 4'h0,  0, 8'h01, 0, 0, 3'd0, 2'b00, 8'h00, 1, 16'd7);
        add(0, 1, 16'h0B2A, 4'h0,  0, 8'h01, 0, 0, 3'd0, 2'b00, 8'h00, 1, 16'd7);
        // reset out of HALT
        add(1, 0, 16'h0000, 4'h0,  0, 8'h00, 0, 0, 3'd0, 2'b00, 8'h00, 0, 16'd7);
        add(0, 0, 16'h0000, 4'h0,  1, 8'h00, 0, 0, 3'd0, 2'b00, 8'h00, 0, 16'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].flags);
            check_vec(i, vecs[i]);
        end

        // reset asserted during an ALU EXEC: no enable, restart at 0
        drive(0, 1, 16'h0B2A, 4'h0);          // accepted at addr 0
        drive(1, 0, 16'h0000, 4'h0);          // EXEC cycle with rst high
        chk("rst_exec.ce_a",  {31'd0, ce_a},  32'd0);
        chk("rst_exec.ce_cy", {31'd0, ce_cy}, 32'd0);
        wait_fetch("rst_exec", 8'h00, 5);

        // self-loop: JMP to own address 0 keeps refetching address 0
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 16'h4000, 4'h0);
            drive(0, 0, 16'h0000, 4'h0);
            wait_fetch($sformatf("selfloop%0d", k), 8'h00, 5);
        end

`ifdef CTRL_SEQ_RETIRE_CNT_EN
        // NOP, ALU, JMP, HALT after a fresh reset retire exactly four
        drive(1, 0, 16'h0000, 4'h0);
        drive(0, 1, 16'h8000, 4'h0);
        drive(0, 0, 16'h0000, 4'h0);
        wait_fetch("ret_nop", 8'h01, 5);
        drive(0, 1, 16'h0B2A, 4'h0);
        drive(0, 0, 16'h0000, 4'h0);
        wait_fetch("ret_alu", 8'h02, 5);
        drive(0, 1, 16'h4005, 4'h0);
        drive(0, 0, 16'h0000, 4'h0);
        wait_fetch("ret_jmp", 8'h05, 5);
        drive(0, 1, 16'hC000, 4'h0);
        drive(0, 0, 16'h0000, 4'h0);
        drive(0, 1, 16'h8000, 4'h0);
        chk("ret_halt.halted", {31'd0, halted}, 32'd1);
        chk("ret_halt.cnt", {16'd0, retired_cnt}, 32'd4);
        for (int k = 0; k < 4; k++) drive(0, 1, 16'h8000, 4'h0);
        chk("ret_hold.cnt", {16'd0, retired_cnt}, 32'd4);
        chk("ret_hold.req", {31'd0, imem_req}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard stop so the bench can never hang
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
